// File: rtl/stc_cu_sched.sv
// stc_cu_sched: sparse-tensor-core control unit for one CSR A-tile at a time.
// Splits tile rows over N_PE workers, strobes accumulate/write-D, then drains rows.
module stc_cu_sched #(
  parameter int M         = 16,
  parameter int N_PE      = 4,
  parameter int DW_ELEIDX = 8,
  parameter int DW_ROWIDX = $clog2(M),
  parameter int DW_BND    = $clog2(M+1),
  parameter int DW_CFG    = (M+1)*DW_ELEIDX + M*DW_ROWIDX + (N_PE+1)*DW_BND
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [DW_CFG-1:0]         cfg_data,
  input  logic [N_PE-1:0]           pe_stall,
  output logic [N_PE*DW_ELEIDX-1:0] A_ptrs,
  output logic [N_PE*DW_ROWIDX-1:0] A_rows,
  output logic [N_PE-1:0]           acc_en,
  output logic [N_PE-1:0]           write_D_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DW_ROWIDX-1:0]      row_out,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_err
);

  localparam int R2_OFF = (M+1)*DW_ELEIDX;
  localparam int BD_OFF = R2_OFF + M*DW_ROWIDX;

  localparam logic [DW_BND-1:0]    M_B    = DW_BND'(M);
  localparam logic [DW_BND-1:0]    ONE_B  = DW_BND'(1);
  localparam logic [DW_ELEIDX-1:0] ONE_E  = DW_ELEIDX'(1);
  localparam logic [DW_ROWIDX-1:0] ONE_R  = DW_ROWIDX'(1);
  localparam logic [DW_ROWIDX-1:0] LAST_R = DW_ROWIDX'(M-1);

  localparam logic [1:0] G_IDLE = 2'd0;
  localparam logic [1:0] G_RUN  = 2'd1;
  localparam logic [1:0] G_OUT  = 2'd2;

  localparam logic [2:0] P_IDLE  = 3'd0;
  localparam logic [2:0] P_LOAD  = 3'd1;
  localparam logic [2:0] P_ROW   = 3'd2;
  localparam logic [2:0] P_FLUSH = 3'd3;
  localparam logic [2:0] P_DONE  = 3'd4;

  logic [DW_ELEIDX-1:0] cfg_rp [M+1];
  logic [DW_ROWIDX-1:0] cfg_r2 [M];
  logic [DW_BND-1:0]    cfg_bd [N_PE+1];
  logic                 err_in;

  logic [DW_ELEIDX-1:0] rp_q [M+1];
  logic [DW_ELEIDX-1:0] rp_d [M+1];
  logic [DW_ROWIDX-1:0] r2_q [M];
  logic [DW_ROWIDX-1:0] r2_d [M];
  logic [DW_BND-1:0]    bd_q [N_PE+1];
  logic [DW_BND-1:0]    bd_d [N_PE+1];

  logic [1:0]           g_q, g_d;
  logic                 err_q, err_d;
  logic [DW_ROWIDX-1:0] rout_q, rout_d;

  logic [2:0]           st_q   [N_PE];
  logic [2:0]           st_d   [N_PE];
  logic [DW_ELEIDX-1:0] ptr_q  [N_PE];
  logic [DW_ELEIDX-1:0] ptr_d  [N_PE];
  logic [DW_ELEIDX-1:0] eptr_q [N_PE];
  logic [DW_ELEIDX-1:0] eptr_d [N_PE];
  logic [DW_BND-1:0]    row_q  [N_PE];
  logic [DW_BND-1:0]    row_d  [N_PE];

  logic accept, fin, all_done;

  always_comb begin
    for (int i = 0; i <= M; i++)
      cfg_rp[i] = cfg_data[i*DW_ELEIDX +: DW_ELEIDX];
    for (int i = 0; i < M; i++)
      cfg_r2[i] = cfg_data[R2_OFF + i*DW_ROWIDX +: DW_ROWIDX];
    for (int i = 0; i <= N_PE; i++)
      cfg_bd[i] = cfg_data[BD_OFF + i*DW_BND +: DW_BND];
  end

  always_comb begin
    err_in = 1'b0;
    for (int j = 0; j < N_PE; j++)
      if (cfg_bd[j] > cfg_bd[j+1] || cfg_bd[j+1] > M_B)
        err_in = 1'b1;
  end

  always_comb begin
    all_done = 1'b1;
    for (int j = 0; j < N_PE; j++)
      if (st_q[j] != P_DONE) all_done = 1'b0;
  end

  assign cfg_ready = (g_q == G_IDLE);
  assign accept    = cfg_valid && cfg_ready;
  assign out_valid = (g_q == G_OUT);
  assign busy      = (g_q != G_IDLE);
  assign row_out   = rout_q;
  assign cfg_err   = err_q;

  always_comb begin
    g_d    = g_q;
    err_d  = err_q;
    rout_d = rout_q;
    rp_d   = rp_q;
    r2_d   = r2_q;
    bd_d   = bd_q;
    done   = 1'b0;
    fin    = 1'b0;
    unique case (g_q)
      G_IDLE: begin
        if (accept) begin
          g_d   = G_RUN;
          err_d = err_in;
          rp_d  = cfg_rp;
          r2_d  = cfg_r2;
          bd_d  = cfg_bd;
        end
      end
      G_RUN: begin
        if (all_done) g_d = G_OUT;
      end
      G_OUT: begin
        if (out_ready) begin
          if (rout_q == LAST_R) begin
            done   = 1'b1;
            fin    = 1'b1;
            g_d    = G_IDLE;
            rout_d = '0;
          end else begin
            rout_d = rout_q + ONE_R;
          end
        end
      end
      default: g_d = G_IDLE;
    endcase
  end

  always_comb begin
    logic adv;
    logic run;
    logic [DW_BND-1:0] rn;
    acc_en     = '0;
    write_D_en = '0;
    for (int j = 0; j < N_PE; j++) begin
      st_d[j]   = st_q[j];
      ptr_d[j]  = ptr_q[j];
      eptr_d[j] = eptr_q[j];
      row_d[j]  = row_q[j];
      adv       = 1'b0;
      run       = !pe_stall[j];
      rn        = row_q[j] + ONE_B;
      unique case (st_q[j])
        P_IDLE: begin
          if (accept) st_d[j] = P_LOAD;
        end
        P_LOAD: begin
          // >= covers both an empty and a reversed (bad) workload
          if (run) begin
            if (bd_q[j] >= bd_q[j+1] || bd_q[j+1] > M_B) begin
              st_d[j] = P_DONE;
            end else begin
              row_d[j]  = bd_q[j];
              ptr_d[j]  = rp_q[bd_q[j]];
              eptr_d[j] = rp_q[bd_q[j] + ONE_B];
              st_d[j]   = P_ROW;
            end
          end
        end
        P_ROW: begin
          if (run) begin
            if (ptr_q[j] < eptr_q[j]) begin
              acc_en[j] = 1'b1;
              ptr_d[j]  = ptr_q[j] + ONE_E;
              if (ptr_q[j] + ONE_E == eptr_q[j]) st_d[j] = P_FLUSH;
            end else begin
              adv = 1'b1;
            end
          end
        end
        P_FLUSH: begin
          if (run) begin
            write_D_en[j] = 1'b1;
            adv           = 1'b1;
          end
        end
        P_DONE: ;
        default: st_d[j] = P_IDLE;
      endcase
      if (adv) begin
        if (rn == bd_q[j+1]) begin
          st_d[j] = P_DONE;
        end else begin
          row_d[j]  = rn;
          ptr_d[j]  = rp_q[rn];
          eptr_d[j] = rp_q[rn + ONE_B];
          st_d[j]   = P_ROW;
        end
      end
      if (fin) st_d[j] = P_IDLE;
    end
  end

  always_comb begin
    for (int j = 0; j < N_PE; j++) begin
      A_ptrs[j*DW_ELEIDX +: DW_ELEIDX] = ptr_q[j];
      A_rows[j*DW_ROWIDX +: DW_ROWIDX] = r2_q[row_q[j][DW_ROWIDX-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      g_q    <= G_IDLE;
      err_q  <= 1'b0;
      rout_q <= '0;
      for (int i = 0; i <= M; i++) rp_q[i] <= '0;
      for (int i = 0; i < M; i++) r2_q[i] <= '0;
      for (int i = 0; i <= N_PE; i++) bd_q[i] <= '0;
      for (int j = 0; j < N_PE; j++) begin
        st_q[j]   <= P_IDLE;
        ptr_q[j]  <= '0;
        eptr_q[j] <= '0;
        row_q[j]  <= '0;
      end
    end else begin
      g_q    <= g_d;
      err_q  <= err_d;
      rout_q <= rout_d;
      rp_q   <= rp_d;
      r2_q   <= r2_d;
      bd_q   <= bd_d;
      for (int j = 0; j < N_PE; j++) begin
        st_q[j]   <= st_d[j];
        ptr_q[j]  <= ptr_d[j];
        eptr_q[j] <= eptr_d[j];
        row_q[j]  <= row_d[j];
      end
    end
  end

endmodule

// File: tb/tb_stc_cu_sched.sv
// tb_stc_cu_sched: scoreboard bench for stc_cu_sched (M=16, N_PE=4).
// Driver queues expected strobes/drain rows; a negedge monitor pops and compares.
module tb_stc_cu_sched;
  localparam int M  = 16;
  localparam int NP = 4;
  localparam int DE = 8;
  localparam int DR = 4;
  localparam int DB = 5;
  localparam int DC = (M+1)*DE + M*DR + (NP+1)*DB;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [DC-1:0] cfg_data = '0;
  logic [NP-1:0] pe_stall = '0;
  logic [NP*DE-1:0] A_ptrs;
  logic [NP*DR-1:0] A_rows;
  logic [NP-1:0] acc_en, write_D_en;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DR-1:0] row_out;
  logic          busy, done, cfg_err;

  stc_cu_sched #(.M(M), .N_PE(NP), .DW_ELEIDX(DE)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .pe_stall(pe_stall), .A_ptrs(A_ptrs), .A_rows(A_rows),
    .acc_en(acc_en), .write_D_en(write_D_en),
    .out_valid(out_valid), .out_ready(out_ready), .row_out(row_out),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wr;
    logic [DE-1:0] ptr;
    logic [DR-1:0] row;
  } ev_t;

  ev_t peq [NP][$];
  int  dq [$];
  int  rp [M+1];
  int  r2r [M];
  int  bd [NP+1];
  int  errs = 0;
  int  checks = 0;
  int  done_cnt = 0;
  int  n = 0;

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    int  er;
    if (reset_n) begin
      for (int j = 0; j < NP; j++) begin
        if (acc_en[j] || write_D_en[j]) begin
          chk(!(acc_en[j] && write_D_en[j]), "excl_strobe", j, -1);
          chk(peq[j].size() > 0, "unexp_strobe", j, -1);
          if (peq[j].size() > 0) begin
            e = peq[j].pop_front();
            chk(write_D_en[j] == e.wr, "strobe_kind", int'(write_D_en[j]), int'(e.wr));
            chk(A_rows[j*DR +: DR] == e.row, "A_rows", int'(A_rows[j*DR +: DR]), int'(e.row));
            if (!e.wr)
              chk(A_ptrs[j*DE +: DE] == e.ptr, "A_ptrs", int'(A_ptrs[j*DE +: DE]), int'(e.ptr));
          end
        end
      end
      if (out_valid && out_ready) begin
        chk(dq.size() > 0, "unexp_row", int'(row_out), -1);
        if (dq.size() > 0) begin
          er = dq.pop_front();
          chk(int'(row_out) == er, "row_out", int'(row_out), er);
          chk(done == (er == M-1), "done", int'(done), int'(er == M-1));
        end
      end else begin
        chk(!done, "done_idle", int'(done), 0);
      end
      if (done) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tstep();
    step();
    n++;
  endtask

  function automatic logic [DC-1:0] pack();
    logic [DC-1:0] v;
    v = '0;
    for (int i = 0; i <= M; i++) v[i*DE +: DE] = DE'(rp[i]);
    for (int i = 0; i < M; i++) v[(M+1)*DE + i*DR +: DR] = DR'(r2r[i]);
    for (int i = 0; i <= NP; i++) v[(M+1)*DE + M*DR + i*DB +: DB] = DB'(bd[i]);
    return v;
  endfunction

  task automatic set_rows(input int nz, input bit rev);
    for (int i = 0; i <= M; i++) rp[i] = i * nz;
    for (int i = 0; i < M; i++) r2r[i] = rev ? (M-1-i) : i;
  endtask

  task automatic set_bnd(input int b0, input int b1, input int b2, input int b3, input int b4);
    bd[0] = b0; bd[1] = b1; bd[2] = b2; bd[3] = b3; bd[4] = b4;
  endtask

  task automatic push_exp();
    ev_t e;
    for (int j = 0; j < NP; j++) begin
      if (bd[j] < bd[j+1] && bd[j+1] <= M) begin
        for (int r = bd[j]; r < bd[j+1]; r++) begin
          for (int p = rp[r]; p < rp[r+1]; p++) begin
            e.wr = 1'b0; e.ptr = DE'(p); e.row = DR'(r2r[r]);
            peq[j].push_back(e);
          end
          if (rp[r+1] > rp[r]) begin
            e.wr = 1'b1; e.ptr = '0; e.row = DR'(r2r[r]);
            peq[j].push_back(e);
          end
        end
      end
    end
    for (int r = 0; r < M; r++) dq.push_back(r);
  endtask

  task automatic issue();
    int k;
    k = 0;
    while (!cfg_ready && k < 50) begin step(); k++; end
    chk(cfg_ready, "cfg_ready_idle", int'(cfg_ready), 1);
    cfg_data  = pack();
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    n = 1;
  endtask

  task automatic run_tile(input int exp_n, input bit exp_err, input bit stall, input bit hold);
    int d0;
    push_exp();
    d0 = done_cnt;
    issue();
    chk(cfg_err == exp_err, "cfg_err", int'(cfg_err), int'(exp_err));
    chk(busy && !cfg_ready, "busy", int'(busy), 1);
    if (stall) begin
      repeat (3) tstep();
      pe_stall = 4'b0100;
      repeat (5) begin
        @(negedge clk);
        chk(!acc_en[2] && !write_D_en[2], "stall_strobe", int'({acc_en[2], write_D_en[2]}), 0);
        chk(A_ptrs[2*DE +: DE] == 8'd26, "stall_ptr", int'(A_ptrs[2*DE +: DE]), 26);
        tstep();
      end
      pe_stall = '0;
    end
    while (!out_valid && n < 400) tstep();
    chk(n == exp_n, "latency", n, exp_n);
    if (hold) begin
      while (!(out_valid && row_out == 4'd7) && n < 400) tstep();
      chk(row_out == 4'd7, "reach_row7", int'(row_out), 7);
      out_ready = 1'b0;
      repeat (3) begin
        tstep();
        chk(out_valid && row_out == 4'd7, "hold_row", int'(row_out), 7);
      end
      out_ready = 1'b1;
    end
    while (busy && n < 600) tstep();
    chk(!busy, "tile_end", int'(busy), 0);
    chk(done_cnt == d0 + 1, "done_once", done_cnt - d0, 1);
    chk(cfg_err == exp_err, "cfg_err_held", int'(cfg_err), int'(exp_err));
    for (int j = 0; j < NP; j++)
      chk(peq[j].size() == 0, "pe_leftover", peq[j].size(), 0);
    chk(dq.size() == 0, "row_leftover", dq.size(), 0);
  endtask

  task automatic chk_reset_outs();
    chk(acc_en == '0 && write_D_en == '0, "rst_strobes", int'({acc_en, write_D_en}), 0);
    chk(A_ptrs == '0, "rst_A_ptrs", int'(A_ptrs), 0);
    chk(A_rows == '0, "rst_A_rows", int'(A_rows), 0);
    chk(!out_valid && row_out == '0, "rst_drain", int'({out_valid, row_out}), 0);
    chk(!busy && !done && !cfg_err, "rst_status", int'({busy, done, cfg_err}), 0);
    chk(cfg_ready, "rst_cfg_ready", int'(cfg_ready), 1);
  endtask

  task automatic set_t2();
    set_rows(1, 1'b0);
    for (int i = 0; i <= 5; i++) rp[i] = i;
    rp[6] = 5;
    for (int i = 7; i <= M; i++) rp[i] = i + 1;
    set_bnd(0, 4, 8, 12, 16);
  endtask

  initial begin
    #23;
    chk_reset_outs();
    step();
    reset_n = 1'b1;
    step();

    set_rows(1, 1'b1);
    set_bnd(0, 4, 8, 12, 16);
    run_tile(11, 1'b0, 1'b0, 1'b0);

    set_t2();
    run_tile(12, 1'b0, 1'b0, 1'b0);

    set_rows(1, 1'b0);
    set_bnd(0, 0, 10, 16, 16);
    run_tile(23, 1'b0, 1'b0, 1'b0);

    set_bnd(0, 9, 4, 16, 16);
    run_tile(27, 1'b1, 1'b0, 1'b0);

    set_rows(3, 1'b1);
    set_bnd(0, 4, 8, 12, 16);
    run_tile(24, 1'b0, 1'b1, 1'b1);

    // abort a tile mid-row with an asynchronous reset
    set_rows(1, 1'b1);
    set_bnd(0, 4, 8, 12, 16);
    push_exp();
    issue();
    repeat (3) step();
    chk(acc_en == 4'hF, "pre_reset_acc", int'(acc_en), 15);
    reset_n = 1'b0;
    #1;
    chk_reset_outs();
    for (int j = 0; j < NP; j++) peq[j].delete();
    dq.delete();
    step();
    reset_n = 1'b1;
    step();

    set_t2();
    run_tile(12, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
